// File: rtl/kernel_kcore_v2h_hls_dl_pkg.sv
// Shared types and constants for the kcore v2h HLS deadlock confirm unit.
// Optional feature macro: KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN (adds dl_cycle_cnt).
package kernel_kcore_v2h_hls_dl_pkg;

  typedef enum logic [1:0] {
    DL_IDLE    = 2'd0,
    DL_PEND    = 2'd1,
    DL_REPORT  = 2'd2,
    DL_CLEARED = 2'd3
  } dl_state_e;

  localparam int DL_CYC_W = 32;

endpackage

// File: rtl/kernel_kcore_v2h_hls_dl_dep_merge.sv
// Valid-masked OR reduction of the incoming dependency bitmaps.
module kernel_kcore_v2h_hls_dl_dep_merge
  import kernel_kcore_v2h_hls_dl_pkg::*;
#(
  parameter int PROC_NUM    = 4,
  parameter int IN_CHAN_NUM = 2
) (
  input  logic [IN_CHAN_NUM-1:0]          vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] data_vec,
  output logic [PROC_NUM-1:0]             dep_comb
);

  // OR together every channel bitmap whose valid is set
  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (vld_vec[i]) dep_comb = dep_comb | data_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

endmodule

// File: rtl/kernel_kcore_v2h_hls_deadlock_confirm_unit.sv
// Per-process deadlock detector: propagates the blocking-dependency bitmap,
// forwards report tokens and confirms a self-dependency over CONFIRM_CYCLES
// consecutive cycles before flagging a deadlock.
// Optional feature macro: KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN adds dl_cycle_cnt,
// the number of cycles spent in REPORT.
module kernel_kcore_v2h_hls_deadlock_confirm_unit
  import kernel_kcore_v2h_hls_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [1:0]                      dl_state
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
  ,
  output logic [DL_CYC_W-1:0]             dl_cycle_cnt
`endif
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(CONFIRM_CYCLES);
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  logic [PROC_NUM-1:0] dep_comb;
  logic [PROC_NUM-1:0] dep;
  logic [PROC_NUM-1:0] dep_reg;
  logic                gate;
  logic                blocked;
  logic                self_hit;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  dl_state_e           state;

`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
  function automatic logic [DL_CYC_W-1:0] cyc_sat_inc(input logic [DL_CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  kernel_kcore_v2h_hls_dl_dep_merge #(
    .PROC_NUM    (PROC_NUM),
    .IN_CHAN_NUM (IN_CHAN_NUM)
  ) u_dep_merge (
    .vld_vec  (in_chan_dep_vld_vec),
    .data_vec (in_chan_dep_data_vec),
    .dep_comb (dep_comb)
  );

  // While a global deadlock is flagged and no token arrives, the bitmap is
  // frozen and no new self-hit can be counted
  always_comb begin
    gate     = ~dl_detect_in | (|token_in_vec);
    blocked  = |proc_dep_vld_vec;
    dep      = gate ? dep_comb : dep_reg;
    self_hit = gate & dep[PROC_ID] & blocked;
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF_BIT;
  assign dl_state             = state;

  // Dependency bitmap register; an unblocked process carries no dependency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dep_reg <= '0;
    else        dep_reg <= blocked ? dep : '0;
  end

  // Report token forwarding; origin wins over token_clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) token_out_vec <= '0;
    else if (((|token_in_vec) & ~token_clear) | origin) token_out_vec <= proc_dep_vld_vec;
    else token_out_vec <= '0;
  end

  // Confirmation FSM with registered deadlock flag and optional REPORT cycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= DL_IDLE;
      cnt           <= '0;
      dl_detect_out <= 1'b0;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
      dl_cycle_cnt  <= '0;
`endif
    end else begin
      case (state)
        DL_IDLE: begin
          if (self_hit) begin
            if (CONFIRM_CYCLES == 1) begin
              state         <= DL_REPORT;
              cnt           <= CNT_MAX;
              dl_detect_out <= 1'b1;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
              dl_cycle_cnt  <= cyc_sat_inc(dl_cycle_cnt);
`endif
            end else begin
              state <= DL_PEND;
              cnt   <= CNT_W'(1);
            end
          end
        end
        DL_PEND: begin
          if (self_hit) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state         <= DL_REPORT;
              dl_detect_out <= 1'b1;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
              dl_cycle_cnt  <= cyc_sat_inc(dl_cycle_cnt);
`endif
            end
          end else begin
            state <= DL_IDLE;
            cnt   <= '0;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
            dl_cycle_cnt <= '0;
`endif
          end
        end
        DL_REPORT: begin
          if (token_clear) begin
            state         <= DL_CLEARED;
            cnt           <= '0;
            dl_detect_out <= 1'b0;
          end else if (!self_hit) begin
            state         <= DL_IDLE;
            cnt           <= '0;
            dl_detect_out <= 1'b0;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
            dl_cycle_cnt  <= '0;
`endif
          end else begin
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
            dl_cycle_cnt <= cyc_sat_inc(dl_cycle_cnt);
`endif
          end
        end
        DL_CLEARED: begin
          if (!blocked) begin
            state <= DL_IDLE;
            cnt   <= '0;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
            dl_cycle_cnt <= '0;
`endif
          end
        end
        default: begin
          state         <= DL_IDLE;
          cnt           <= '0;
          dl_detect_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_kcore_v2h_hls_deadlock_confirm_unit.sv
// Self-checking bench for the kcore v2h deadlock confirm unit.
module tb_kernel_kcore_v2h_hls_deadlock_confirm_unit;

  localparam int PN = 4;
  localparam int PID = 1;
  localparam int ICN = 2;
  localparam int OCN = 3;
  localparam int CC = 3;

  logic            clock;
  logic            reset;
  logic [OCN-1:0]  proc_dep_vld_vec;
  logic [ICN-1:0]  in_chan_dep_vld_vec;
  logic [ICN*PN-1:0] in_chan_dep_data_vec;
  logic [ICN-1:0]  token_in_vec;
  logic            dl_detect_in;
  logic            origin;
  logic            token_clear;
  logic [OCN-1:0]  out_chan_dep_vld_vec;
  logic [PN-1:0]   out_chan_dep_data;
  logic [OCN-1:0]  token_out_vec;
  logic            dl_detect_out;
  logic [1:0]      dl_state;
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
  logic [31:0]     dl_cycle_cnt;
`endif

  kernel_kcore_v2h_hls_deadlock_confirm_unit #(
    .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(ICN),
    .OUT_CHAN_NUM(OCN), .CONFIRM_CYCLES(CC)
  ) dut (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(proc_dep_vld_vec),
    .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
    .in_chan_dep_data_vec(in_chan_dep_data_vec),
    .token_in_vec(token_in_vec),
    .dl_detect_in(dl_detect_in),
    .origin(origin),
    .token_clear(token_clear),
    .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
    .out_chan_dep_data(out_chan_dep_data),
    .token_out_vec(token_out_vec),
    .dl_detect_out(dl_detect_out),
    .dl_state(dl_state)
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
    , .dl_cycle_cnt(dl_cycle_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: length of the current run of consecutive self-hits,
  // whether the report was acknowledged, the dependency register, tokens
  // and time spent reporting.
  int          run;
  bit          acked;
  logic [PN-1:0]  m_dep;
  logic [OCN-1:0] m_tok;
  logic [31:0] m_cyc;

  function automatic int exp_state();
    if (acked) return 3;
    if (run >= CC) return 2;
    if (run > 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 0; acked = 0; m_dep = '0; m_tok = '0; m_cyc = '0;
  endtask

  task automatic check_outputs();
    chk("state", 32'(dl_state), 32'(exp_state()));
    chk("detect", 32'(dl_detect_out), 32'(exp_state() == 2));
    chk("token", 32'(token_out_vec), 32'(m_tok));
    chk("dep_data", 32'(out_chan_dep_data), 32'(m_dep | PN'(1 << PID)));
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
    chk("cyc_cnt", dl_cycle_cnt, m_cyc);
`endif
  endtask

  // One clock: model the edge from the currently driven inputs, then check
  task automatic tick();
    bit gate, hit;
    logic [PN-1:0] dcomb, dnow;
    #1;
    chk("dep_vld_passthru", 32'(out_chan_dep_vld_vec), 32'(proc_dep_vld_vec));
    gate = !dl_detect_in || (token_in_vec != 0);
    dcomb = '0;
    for (int i = 0; i < ICN; i++)
      if (in_chan_dep_vld_vec[i]) dcomb = dcomb | in_chan_dep_data_vec[i*PN +: PN];
    dnow = gate ? dcomb : m_dep;
    hit = gate && dnow[PID] && (proc_dep_vld_vec != 0);
    @(posedge clock);
    #1;
    m_dep = (proc_dep_vld_vec != 0) ? dnow : '0;
    m_tok = (((token_in_vec != 0) && !token_clear) || origin) ? proc_dep_vld_vec : '0;
    if (acked) begin
      if (proc_dep_vld_vec == 0) acked = 0;
      run = 0;
    end else if (run >= CC) begin
      if (token_clear) begin acked = 1; run = 0; end
      else if (!hit) run = 0;
    end else begin
      run = hit ? run + 1 : 0;
    end
    if (exp_state() == 2) m_cyc = (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
    else if (exp_state() == 0) m_cyc = '0;
    check_outputs();
  endtask

  task automatic idle_inputs();
    proc_dep_vld_vec = '0; in_chan_dep_vld_vec = '0; in_chan_dep_data_vec = '0;
    token_in_vec = '0; dl_detect_in = 1'b0; origin = 1'b0; token_clear = 1'b0;
  endtask

  task automatic hit_inputs();
    idle_inputs();
    in_chan_dep_vld_vec = 2'b01;
    in_chan_dep_data_vec = 8'b0000_0010;
    proc_dep_vld_vec = 3'b001;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    // reset state
    chk("rst_dep_data", 32'(out_chan_dep_data), 32'h2);
    chk("rst_token", 32'(token_out_vec), 32'h0);
    chk("rst_detect", 32'(dl_detect_out), 32'h0);
    chk("rst_state", 32'(dl_state), 32'h0);

    // three consecutive hits confirm the deadlock
    hit_inputs();
    tick(); chk("plan_s1", 32'(dl_state), 32'd1);
    tick(); chk("plan_s2", 32'(dl_state), 32'd1);
    chk("plan_no_detect", 32'(dl_detect_out), 32'd0);
    tick(); chk("plan_s3", 32'(dl_state), 32'd2);
    chk("plan_detect", 32'(dl_detect_out), 32'd1);
    repeat (4) tick();
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
    chk("plan_cyc5", dl_cycle_cnt, 32'd5);
`endif

    // acknowledge then release
    token_clear = 1'b1;
    tick(); chk("plan_cleared", 32'(dl_state), 32'd3);
    chk("plan_clr_detect", 32'(dl_detect_out), 32'd0);
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
    chk("plan_cyc_hold", dl_cycle_cnt, 32'd5);
`endif
    token_clear = 1'b0;
    tick(); chk("plan_cleared_hold", 32'(dl_state), 32'd3);
    proc_dep_vld_vec = '0;
    tick(); chk("plan_back_idle", 32'(dl_state), 32'd0);
`ifdef KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN
    chk("plan_cyc_zero", dl_cycle_cnt, 32'd0);
`endif

    // transient loop: hits stop after two edges
    hit_inputs();
    tick(); tick();
    in_chan_dep_vld_vec = '0;
    tick(); chk("plan_transient", 32'(dl_state), 32'd0);
    chk("plan_transient_det", 32'(dl_detect_out), 32'd0);

    // global flag without a token aborts PEND; then origin forwards tokens
    hit_inputs();
    tick(); chk("plan_pend", 32'(dl_state), 32'd1);
    dl_detect_in = 1'b1;
    tick(); chk("plan_frozen_idle", 32'(dl_state), 32'd0);
    idle_inputs();
    origin = 1'b1;
    proc_dep_vld_vec = 3'b101;
    tick(); chk("plan_origin_tok", 32'(token_out_vec), 32'h5);
    origin = 1'b0;
    token_in_vec = 2'b10;
    token_clear = 1'b1;
    tick(); chk("plan_tok_cleared", 32'(token_out_vec), 32'h0);

    // asynchronous reset in the middle of a confirmation run
    hit_inputs();
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_state", 32'(dl_state), 32'd0);
    chk("async_data", 32'(out_chan_dep_data), 32'h2);
    chk("async_token", 32'(token_out_vec), 32'h0);
    reset = 1'b1;
    tick(); chk("async_restart", 32'(dl_state), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      proc_dep_vld_vec = ($urandom_range(0, 99) < 85) ? OCN'($urandom_range(1, 7)) : '0;
      in_chan_dep_vld_vec[0] = ($urandom_range(0, 99) < 80);
      in_chan_dep_vld_vec[1] = ($urandom_range(0, 99) < 30);
      for (int i = 0; i < ICN; i++) begin
        in_chan_dep_data_vec[i*PN +: PN] = PN'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < 75) in_chan_dep_data_vec[i*PN + PID] = 1'b1;
      end
      dl_detect_in = ($urandom_range(0, 99) < 10);
      token_in_vec = ($urandom_range(0, 99) < 25) ? ICN'($urandom_range(1, 3)) : '0;
      origin = ($urandom_range(0, 99) < 15);
      token_clear = ($urandom_range(0, 99) < 10);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kernel_kcore_v2h_hls_deadlock_confirm_unit.md
# kernel_kcore_v2h_hls_deadlock_confirm_unit

Per-process deadlock detection unit with multi-cycle confirmation, for the kcore v2h HLS dataflow region; one instance per process. It propagates the blocking-dependency bitmap through the process-dependency network and forwards report tokens. It asserts a deadlock only after a self-dependency persists for `CONFIRM_CYCLES` consecutive cycles, which filters transient back-pressure loops. A reported deadlock is held until the token controller clears it.

## Interface
- `PROC_NUM`, 4: number of processes; width of the dependency bitmap.
- `PROC_ID`, 0: this process's bit index, 0..PROC_NUM-1.
- `IN_CHAN_NUM`, 2: incoming dependency channels.
- `OUT_CHAN_NUM`, 3: outgoing dependency channels.
- `CONFIRM_CYCLES`, 4: consecutive self-hit cycles needed to report; ≥1.
- `CNT_W`, `$clog2(CONFIRM_CYCLES+1)`: width of the confirmation counter (localparam).
- `clock`  in  1  clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `proc_dep_vld_vec`  in  OUT_CHAN_NUM  process is blocked on output channel k.
- `in_chan_dep_vld_vec`  in  IN_CHAN_NUM  incoming dependency valid, per channel.
- `in_chan_dep_data_vec`  in  IN_CHAN_NUM*PROC_NUM  incoming bitmaps; channel i occupies `[i*PROC_NUM +: PROC_NUM]`.
- `token_in_vec`  in  IN_CHAN_NUM  incoming report tokens.
- `dl_detect_in`  in  1  global deadlock-detected flag.
- `origin`  in  1  this process originates the report token.
- `token_clear`  in  1  controller acknowledges and clears the report.
- `out_chan_dep_vld_vec`  out  OUT_CHAN_NUM  equals `proc_dep_vld_vec` (combinational).
- `out_chan_dep_data`  out  PROC_NUM  `dep_reg | (1<<PROC_ID)`.
- `token_out_vec`  out  OUT_CHAN_NUM  registered outgoing tokens.
- `dl_detect_out`  out  1  registered confirmed-deadlock flag.
- `dl_state`  out  2  FSM state: IDLE=0, PEND=1, REPORT=2, CLEARED=3.

## Operation
- `gate = ~dl_detect_in | (|token_in_vec)`.
- `dep_comb` = OR over i of (`in_chan_dep_vld_vec[i]` ? data_i : 0).
- `dep = gate ? dep_comb : dep_reg`.
- `dep_reg` is updated to `dep` when `|proc_dep_vld_vec`; otherwise it is updated to 0.
- `self_hit = gate & dep[PROC_ID] & (|proc_dep_vld_vec)`.
- `cnt` is CNT_W bits and saturating.
- FSM transitions:
  - IDLE: on `self_hit`, go to REPORT if CONFIRM_CYCLES==1; otherwise go to PEND with cnt=1.
  - PEND: on `self_hit`, cnt++; go to REPORT once cnt reaches CONFIRM_CYCLES. On `~self_hit`, go to IDLE with cnt=0.
  - REPORT: on `token_clear`, go to CLEARED. Else on `~self_hit`, go to IDLE (deadlock resolved). `token_clear` takes priority over `~self_hit`.
  - CLEARED: go to IDLE when `proc_dep_vld_vec==0`; otherwise stay. `self_hit` is ignored in CLEARED.
- `dl_detect_out` = (state==REPORT).
- Token update: if `(|token_in_vec & ~token_clear) | origin`, then `token_out_vec <= proc_dep_vld_vec`; else `token_out_vec <= 0`. `origin` overrides `token_clear`.

## Timing
- Reset values:
  - `dep_reg`=0, `token_out_vec`=0, `dl_detect_out`=0, state IDLE, cnt=0.
  - Hence `out_chan_dep_data`=onehot(PROC_ID).
- Detection latency: `dl_detect_out` rises in the cycle after the CONFIRM_CYCLES-th consecutive hit edge.
- Clear latency: `dl_detect_out` falls in the cycle after the edge that samples `token_clear` or `~self_hit`.
- Token latency: 1 cycle.
- Dependency latency: 1 cycle through `dep_reg`.
- Reset asserted mid-operation forces every register to its reset value immediately (asynchronously). No partial count survives.
- `dl_detect_in=1` with no token freezes `dep` at `dep_reg` and makes `self_hit`=0, so a PEND sequence aborts to IDLE.

## Configuration
- Macro: `KERNEL_KCORE_V2H_DL_CYCLE_CNT_EN`.
- With the macro defined:
  - Adds output `dl_cycle_cnt` [31:0].
  - It increments every cycle the FSM is in REPORT and saturates at 32'hFFFF_FFFF.
  - It holds its value in CLEARED, is cleared on entry to IDLE, and resets to 0.
- Without the macro: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `kernel_kcore_v2h_hls_dl_pkg` holds:
  - the 2-bit state type and the encodings IDLE/PEND/REPORT/CLEARED;
  - the `dl_cycle_cnt` width constant.
- One sub-module, `kernel_kcore_v2h_hls_dl_dep_merge`: the parametrised valid-masked OR reduction that produces `dep_comb`.
- FSM, counters and token logic live in the top module.

## Test plan
Common setup: PROC_NUM=4, PROC_ID=1, IN_CHAN_NUM=2, OUT_CHAN_NUM=3, CONFIRM_CYCLES=3.
- Reset release -> `out_chan_dep_data`=4'b0010, `token_out_vec`=0, `dl_detect_out`=0, `dl_state`=0.
- ch0 vld, data 4'b0010, `proc_dep_vld_vec`=3'b001, `dl_detect_in`=0 for 3 edges -> `dl_state` goes 1,1,2; `dl_detect_out`=1 after the 3rd edge.
- Same stimulus but vld drops after 2 edges -> `dl_state` returns to 0; `dl_detect_out` never asserts.
- In REPORT, pulse `token_clear` -> next cycle `dl_state`=3, `dl_detect_out`=0. Then `proc_dep_vld_vec`=0 -> `dl_state`=0.
- `dl_detect_in`=1, `token_in_vec`=0 during PEND -> IDLE. Then `origin`=1 with `proc_dep_vld_vec`=3'b101 -> `token_out_vec`=3'b101 one cycle later.
- With the macro defined, hold REPORT for 5 cycles -> `dl_cycle_cnt`=5. Then `token_clear` -> value held at 5. Then IDLE -> 0.
